// File: rtl/fpalu_sequencer.sv
// Multi-cycle issue controller between FP decode and the FP ALU: registers one op,
// holds it stable on the ALU inputs for its latency, then captures result and flags.
module fpalu_sequencer #(
  parameter int LAT_ADDSUB = 7,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 6,
  parameter int LAT_SQRT   = 16,
  parameter int LAT_CMP    = 1,
  parameter int LAT_CVT    = 6,
  parameter int CNT_W      = 5
) (
  input  logic        iclock,
  input  logic        ireset,
  input  logic        istart,
  input  logic        iflush,
  input  logic [4:0]  icontrol,
  input  logic [31:0] idataa,
  input  logic [31:0] idatab,
  output logic [4:0]  oalu_control,
  output logic [31:0] oalu_dataa,
  output logic [31:0] oalu_datab,
  input  logic [31:0] ialu_result,
  input  logic        ialu_nan,
  input  logic        ialu_zero,
  input  logic        ialu_overflow,
  input  logic        ialu_underflow,
  input  logic        ialu_comp,
  output logic [31:0] oresult,
  output logic        onan,
  output logic        ozero,
  output logic        ooverflow,
  output logic        ounderflow,
  output logic        ocomp,
  output logic        obusy,
  output logic        odone,
  output logic        ostall
);

  localparam logic [4:0] FOPADD   = 5'd0;
  localparam logic [4:0] FOPSUB   = 5'd1;
  localparam logic [4:0] FOPMUL   = 5'd2;
  localparam logic [4:0] FOPDIV   = 5'd3;
  localparam logic [4:0] FOPSQRT  = 5'd4;
  localparam logic [4:0] FOPABS   = 5'd5;
  localparam logic [4:0] FOPNEG   = 5'd6;
  localparam logic [4:0] FOPCEQ   = 5'd7;
  localparam logic [4:0] FOPCLT   = 5'd8;
  localparam logic [4:0] FOPCLE   = 5'd9;
  localparam logic [4:0] FOPCVTSW = 5'd10;
  localparam logic [4:0] FOPCVTWS = 5'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] lat_sel_s;
  logic             can_accept_s;
  logic             accept_s;

  // Per-opcode ALU latency; ABS/NEG are combinational inside the ALU.
  always_comb begin
    lat_sel_s = {CNT_W{1'b0}};
    case (icontrol)
      FOPADD, FOPSUB:             lat_sel_s = CNT_W'(LAT_ADDSUB);
      FOPMUL:                     lat_sel_s = CNT_W'(LAT_MUL);
      FOPDIV:                     lat_sel_s = CNT_W'(LAT_DIV);
      FOPSQRT:                    lat_sel_s = CNT_W'(LAT_SQRT);
      FOPCEQ, FOPCLT, FOPCLE:     lat_sel_s = CNT_W'(LAT_CMP);
      FOPCVTSW, FOPCVTWS:         lat_sel_s = CNT_W'(LAT_CVT);
      FOPABS, FOPNEG:             lat_sel_s = {CNT_W{1'b0}};
      default:                    lat_sel_s = {CNT_W{1'b0}};
    endcase
  end

  // Accept qualification and CPU stall; stall drops on the done cycle unless a new op arrives.
  always_comb begin
    can_accept_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    accept_s     = istart && !iflush && can_accept_s;
    if (state_r == ST_EXEC) begin
      ostall = 1'b1;
    end else begin
      ostall = istart && can_accept_s;
    end
  end

  // Sequencer state, operand hold registers and result capture.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      oalu_control <= 5'd0;
      oalu_dataa   <= 32'd0;
      oalu_datab   <= 32'd0;
      oresult      <= 32'd0;
      onan         <= 1'b0;
      ozero        <= 1'b0;
      ooverflow    <= 1'b0;
      ounderflow   <= 1'b0;
      ocomp        <= 1'b0;
      obusy        <= 1'b0;
      odone        <= 1'b0;
    end else begin
      odone <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            oalu_control <= icontrol;
            oalu_dataa   <= idataa;
            oalu_datab   <= idatab;
            cnt_r        <= lat_sel_s;
            state_r      <= ST_EXEC;
            obusy        <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (iflush) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            obusy   <= 1'b0;
          end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
          end else begin
            oresult    <= ialu_result;
            onan       <= ialu_nan;
            ozero      <= ialu_zero;
            ooverflow  <= ialu_overflow;
            ounderflow <= ialu_underflow;
            ocomp      <= ialu_comp;
            odone      <= 1'b1;
            obusy      <= 1'b0;
            state_r    <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          obusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fpalu_sequencer.md
Name: fpalu_sequencer

Overview:
- Multi-cycle issue controller placed between the FP register-file/decode stage and the floating-point ALU.
- Registers one FP operation and holds its operands and control code stable on the ALU inputs.
- Waits the op-specific pipeline latency of the ALU megafunctions, then captures the result and flags into output registers.
- Raises a stall to the CPU while an op is in flight and pulses done when the result is valid.

Parameters:
- LAT_ADDSUB, 7, ALU cycles for FOPADD/FOPSUB
- LAT_MUL, 5, cycles for FOPMUL
- LAT_DIV, 6, cycles for FOPDIV
- LAT_SQRT, 16, cycles for FOPSQRT
- LAT_CMP, 1, cycles for FOPCEQ/FOPCLT/FOPCLE
- LAT_CVT, 6, cycles for FOPCVTSW/FOPCVTWS
- CNT_W, 5, latency counter width; every LAT_* must be ≤ 2^CNT_W−1

Ports:
- iclock  in  1  system clock, all state updates on its rising edge
- ireset  in  1  asynchronous, active-high reset
- istart  in  1  request to issue an op
- iflush  in  1  abort the op in flight, synchronous
- icontrol  in  5  FOP* opcode from the shared parameter header
- idataa  in  32  operand A
- idatab  in  32  operand B
- oalu_control  out  5  registered opcode driven to the ALU
- oalu_dataa  out  32  registered operand A to the ALU
- oalu_datab  out  32  registered operand B to the ALU
- ialu_result  in  32  ALU result
- ialu_nan  in  1  ALU NaN flag
- ialu_zero  in  1  ALU zero flag
- ialu_overflow  in  1  ALU overflow flag
- ialu_underflow  in  1  ALU underflow flag
- ialu_comp  in  1  ALU compare result
- oresult  out  32  captured result
- onan  out  1  captured NaN flag
- ozero  out  1  captured zero flag
- ooverflow  out  1  captured overflow flag
- ounderflow  out  1  captured underflow flag
- ocomp  out  1  captured compare result
- obusy  out  1  op in flight
- odone  out  1  one-cycle result-valid pulse
- ostall  out  1  combinational CPU stall

Behaviour:
- Reset (asynchronous, ireset=1):
  - state=IDLE, counter=0.
  - All oalu_* = 0, oresult = 0.
  - All flags, ocomp, obusy and odone = 0.
- States: IDLE, EXEC, DONE.
- Latency select (combinational from icontrol):
  - FOPABS, FOPNEG and unknown opcodes: 0.
  - All other opcodes: the matching LAT_* parameter.
- Accept:
  - Condition: istart=1 and iflush=0 at an edge while in IDLE or DONE.
  - Latches idataa, idatab and icontrol into oalu_*.
  - Loads counter with the selected latency.
  - Next state is EXEC.
- Holding: oalu_* hold their value until the next accept; they never change while in EXEC.
- EXEC:
  - Counter nonzero: decrement each edge.
  - Counter 0: capture ialu_* into oresult, the flags and ocomp; next state is DONE.
- Timing:
  - odone is high exactly LAT+1 cycles after the accepting edge.
  - ABS and NEG give odone after 1 cycle.
- DONE:
  - odone=1 for this single cycle; outputs hold their captured values.
  - Next state is IDLE, or EXEC on a back-to-back accept.
- Output hold: captured outputs change only at a capture edge or on reset. They are not cleared on accept.
- obusy = 1 in EXEC, registered by state.
- ostall:
  - 1 in EXEC.
  - 1 when istart=1 in IDLE or DONE (covers the accept cycle).
  - 0 in DONE with no new istart, so the CPU advances on the done cycle.
- istart while in EXEC: ignored. No queueing and no error.
- iflush:
  - In EXEC: next state IDLE, counter=0, no capture, no odone; captured outputs keep their old values.
  - In DONE: has no effect on the pulse already in progress.
  - Simultaneous with istart: iflush wins; the op is not accepted.
- Opcode change while busy: the ALU control is the registered copy, so the ALU never sees icontrol glitches mid-op (important for the add_sub direction line).
- Reset mid-op: returns to IDLE within the same cycle; no odone is produced afterwards.

Test Plan:
- FOPADD, A=0x3F800000, B=0x40000000 (ALU model with 7-cycle latency) -> ostall high 8 cycles; odone at cycle 8; oresult=0x40400000; all flags 0.
- FOPSQRT, A=0xC0800000 -> odone at cycle 17; onan=1; ostall held the whole time; a mid-op istart with FOPMUL is ignored and oalu_control stays FOPSQRT.
- FOPNEG, A=0x40490FDB -> odone 1 cycle after accept; oresult=0xC0490FDB. Then issue FOPCLT back-to-back in the DONE cycle, A=1.0, B=2.0 -> ocomp=1 at cycle 2.
- FOPDIV accepted, iflush asserted at cycle 3 -> state returns to IDLE; no odone; oresult retains the previous value; obusy=0 next cycle.
- FOPMUL accepted, ireset pulsed asynchronously at cycle 2 mid-clock -> all outputs 0 immediately; no odone afterwards; a new FOPMUL 3.0×2.0 then yields 0x40C00000 at cycle 6.
